sync_timer_nb: RTL
==================

# sync_timer_nb

Parametrised synchronous timer/counter, the general-purpose successor to the team's fixed 4-bit synchronous counter. It adds N-bit width, a programmable prescaler, up/down direction, periodic (auto-reload) or one-shot mode, synchronous load, and a compare-match pulse. It sits in the timer subsystem as the base tick/period generator feeding interrupt and PWM logic.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- PRE_W, 4, prescaler select width; tick divide ratio = psc+1 (1..2^PRE_W)
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-high; one clock domain, no other reset
- cten  in  1  count enable; 1 = run, 0 = stop and hold
- prs  in  1  synchronous preset: out ← start value (0 up, reload down)
- ld  in  1  synchronous load: out ← ld_val
- ld_val  in  WIDTH  load value
- dir  in  1  0 = up, 1 = down
- mode  in  1  0 = periodic (auto-reload), 1 = one-shot
- reload  in  WIDTH  period bound (up: terminal value; down: restart value)
- cmp  in  WIDTH  compare value
- psc  in  PRE_W  prescaler select
- out  out  WIDTH  counter value
- tc  out  1  terminal-count pulse, one clk wide
- match  out  1  compare-match pulse, one clk wide
- run  out  1  high while FSM in RUN

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE→RUN: cten=1. RUN→IDLE: cten=0 (out holds). RUN→DONE: one-shot terminal tick. DONE→IDLE: cten=0, prs=1 or ld=1.
- Prescaler pre_cnt (PRE_W bits) counts only in RUN; tick when pre_cnt==psc, then pre_cnt←0. pre_cnt←0 on prs, ld, and any exit from RUN.
- Count step, on tick only, in RUN:
  - up: if out ≥ reload → terminal: periodic out←0, one-shot out holds; else out←out+1.
  - down: if out==0 → terminal: periodic out←reload, one-shot out holds; else out←out−1.
- Priority per edge: clr > prs > ld > count. prs/ld in RUN keep state RUN; in DONE go to IDLE.
- tc=1 for the cycle following the edge consuming a terminal tick (both modes).
- match=1 for the cycle following any count-step edge whose new out==cmp. ld/prs never raise match or tc.
- dir, mode, reload, cmp, psc sampled every edge; changes take effect at the next tick.
- Up with out > reload (reload lowered or ld_val > reload): next tick is terminal.
- Arithmetic is modulo 2^WIDTH; no other wrap path exists.

## Timing
- Reset values: out=0, tc=0, match=0, run=0, pre_cnt=0, state IDLE.
- clr asserted mid-count clears everything immediately (asynchronous); first count no earlier than 2 edges after clr deasserts with cten=1.
- cten sampled high at edge N (IDLE) → run=1 after N; first tick at edge N+1+psc, then every psc+1 edges.
- psc=0: one step per clk in RUN.
- Periodic up period = (reload+1)·(psc+1) clk; down identical.
- tc and match are registered; both may be high in the same cycle (cmp equals wrap value).
- cten low at a tick edge: no step, state→IDLE on that edge.

## Test plan
- WIDTH=4, psc=0, up, periodic, reload=9, cten=1 after clr: out 0..9,0; tc high one cycle when out becomes 0, every 10 clk.
- psc=3, down, periodic, reload=5, prs then cten=1: out 5,4..0,5 stepping every 4 clk; tc period 24 clk.
- One-shot up, reload=3: out 0,1,2,3, holds 3, tc one pulse, run→0 (DONE); ld=1 ld_val=0 → IDLE, out=0, no tc.
- cmp=6, up, reload=15: match one cycle with out==6 each period; ld ld_val=6 → out=6, match stays 0.
- Priority: prs, ld, tick same edge → out=start value; clr pulse mid-run (out=7) → out=0, run=0 immediately.
- Up, out=12, reload lowered to 8 → next tick wraps to 0 with tc; cten dropped mid-period → out holds, resumes after psc+1 edges.

Source files
------------

// File: rtl/sync_timer_nb.sv
`default_nettype none
// ============================================================================
// Module      : sync_timer_nb
// Description : Parametrised timer/counter with prescaler, up/down direction,
//               periodic or one-shot mode, preset/load and compare match.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_timer_nb #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cten,
    input  logic             prs,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] reload,
    input  logic [WIDTH-1:0] cmp,
    input  logic [PRE_W-1:0] psc,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             match,
    output logic             run
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PRE_W-1:0]   r_pre_cnt;
    logic [PRE_W-1:0]   w_pre_nxt;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   w_out_nxt;
    logic               r_tc;
    logic               w_tc_nxt;
    logic               r_match;
    logic               w_match_nxt;
    logic               w_tick;
    logic               w_term;
    logic [WIDTH-1:0]   w_start;
    logic [WIDTH-1:0]   w_step;

    // A tick is only consumed while running and still enabled.
    assign w_tick  = (r_state == S_RUN) && cten && (r_pre_cnt == psc);
    // Up-count uses >= so an out value above a lowered reload wraps next tick.
    assign w_term  = dir ? (r_out == '0) : (r_out >= reload);
    assign w_start = dir ? reload : '0;
    assign w_step  = dir ? (r_out - 1'b1) : (r_out + 1'b1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_pre_cnt <= '0;
            r_out     <= '0;
            r_tc      <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre_cnt <= w_pre_nxt;
            r_out     <= w_out_nxt;
            r_tc      <= w_tc_nxt;
            r_match   <= w_match_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cten) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!cten) begin
                    w_state_nxt = S_IDLE;
                end else if (!prs && !ld && w_tick && w_term && mode) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!cten || prs || ld) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pre_nxt   = '0;
        w_out_nxt   = r_out;
        w_tc_nxt    = 1'b0;
        w_match_nxt = 1'b0;

        if ((r_state == S_RUN) && (w_state_nxt == S_RUN) && !prs && !ld && !w_tick) begin
            w_pre_nxt = r_pre_cnt + 1'b1;
        end

        if (prs) begin
            w_out_nxt = w_start;
        end else if (ld) begin
            w_out_nxt = ld_val;
        end else if (w_tick) begin
            if (w_term) begin
                w_tc_nxt = 1'b1;
                // One-shot holds at the terminal value without a new step.
                if (!mode) begin
                    w_out_nxt   = w_start;
                    w_match_nxt = (w_start == cmp);
                end
            end else begin
                w_out_nxt   = w_step;
                w_match_nxt = (w_step == cmp);
            end
        end
    end

    assign out   = r_out;
    assign tc    = r_tc;
    assign match = r_match;
    assign run   = (r_state == S_RUN);

endmodule
`default_nettype wire
